boot_run_ctrl: RTL and testbench

//  Sequencer for the single-cycle cpu: loads a program from a byte stream into instruction memory.

---
 rtl/boot_run_ctrl_if.sv | 42 ++++
 rtl/boot_run_ctrl.sv | 142 ++++++++++++++
 tb/tb_boot_run_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_run_ctrl_if.sv
// Signal bundle between boot_run_ctrl and its neighbours: host byte link, imem write port
// and the cpu reset / data-bus taps. The master side is the controller.
interface boot_run_ctrl_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;

    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    logic        cpu_n_reset;
    logic [31:0] cpu_dataAddr;
    logic [31:0] cpu_writeData;
    logic        cpu_we;

    modport master (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata,
        output cpu_n_reset,
        input  cpu_dataAddr,
        input  cpu_writeData,
        input  cpu_we
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata,
        input  cpu_n_reset,
        output cpu_dataAddr,
        output cpu_writeData,
        output cpu_we
    );
endinterface

// File: rtl/boot_run_ctrl.sv
// Boot/run sequencer: streams a little-endian program into imem, holds the cpu in reset,
// then runs it until a halt store or a cycle timeout, reporting exit code and cycle count.
module boot_run_ctrl #(
    parameter int unsigned LEN_W      = 16,
    parameter logic [31:0] LOAD_BASE  = 32'h0000_0000,
    parameter logic [31:0] HALT_ADDR  = 32'hFFFF_FFF0,
    parameter int unsigned RST_CYCLES = 2,
    parameter logic [31:0] MAX_CYCLES = 32'd100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] prog_len,
    boot_run_ctrl_if.master  bus,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [31:0]      exit_code,
    output logic [31:0]      cycle_count
);

    localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StReset,
        StRun,
        StDone
    } stateT;

    stateT            state;
    logic [1:0]       bytePhase;
    logic [LEN_W-1:0] wordIdx;
    logic [LEN_W-1:0] progLen;
    logic [23:0]      byteBuf;
    logic [RstW-1:0]  rstCnt;

    logic             imemWe;
    logic [31:0]      imemAddr;
    logic [31:0]      imemWdata;
    logic             cpuNReset;

    logic             halt;
    logic             lastWord;
    logic             rstDone;
    logic             hitMax;
    logic [31:0]      countNext;

    assign bus.rx_ready    = (state == StLoad);
    assign bus.imem_we     = imemWe;
    assign bus.imem_addr   = imemAddr;
    assign bus.imem_wdata  = imemWdata;
    assign bus.cpu_n_reset = cpuNReset;

    assign halt      = bus.cpu_we && (bus.cpu_dataAddr == HALT_ADDR);
    assign lastWord  = (wordIdx == progLen - LEN_W'(1));
    assign rstDone   = (rstCnt == RstW'(RST_CYCLES - 1));
    assign hitMax    = (cycle_count == MAX_CYCLES - 32'd1);
    assign countNext = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            bytePhase   <= 2'd0;
            wordIdx     <= '0;
            progLen     <= '0;
            byteBuf     <= '0;
            rstCnt      <= '0;
            imemWe      <= 1'b0;
            imemAddr    <= '0;
            imemWdata   <= '0;
            cpuNReset   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            exit_code   <= '0;
            cycle_count <= '0;
        end else begin
            imemWe <= 1'b0;
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        done        <= 1'b0;
                        timeout     <= 1'b0;
                        exit_code   <= '0;
                        cycle_count <= '0;
                        busy        <= 1'b1;
                        progLen     <= prog_len;
                        wordIdx     <= '0;
                        bytePhase   <= 2'd0;
                        rstCnt      <= '0;
                        state       <= (prog_len != '0) ? StLoad : StReset;
                    end
                end
                StLoad: begin
                    // rx_ready is implied by being in this state
                    if (bus.rx_valid) begin
                        bytePhase <= bytePhase + 2'd1;
                        if (bytePhase == 2'd3) begin
                            imemWe    <= 1'b1;
                            imemWdata <= {bus.rx_data, byteBuf};
                            imemAddr  <= LOAD_BASE + (32'(wordIdx) << 2);
                            wordIdx   <= wordIdx + LEN_W'(1);
                            if (lastWord) begin
                                rstCnt <= '0;
                                state  <= StReset;
                            end
                        end else begin
                            byteBuf[8*bytePhase +: 8] <= bus.rx_data;
                        end
                    end
                end
                StReset: begin
                    if (rstDone) begin
                        cpuNReset <= 1'b1;
                        state     <= StRun;
                    end else begin
                        rstCnt <= rstCnt + RstW'(1);
                    end
                end
                StRun: begin
                    cycle_count <= countNext;
                    // halt takes priority over a coincident timeout
                    if (halt || hitMax) begin
                        if (halt) begin
                            exit_code <= bus.cpu_writeData;
                        end else begin
                            timeout <= 1'b1;
                        end
                        cpuNReset <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= StDone;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_run_ctrl.sv
// Self-checking bench for boot_run_ctrl: scoreboarded imem writes plus per-scenario checks
// of reset hold, run, halt, timeout, ignored start and load abort.
module tb_boot_run_ctrl;

    localparam logic [31:0] LoadBase  = 32'h0000_1000;
    localparam logic [31:0] HaltAddr  = 32'hFFFF_FFF0;
    localparam int unsigned RstCycles = 2;
    localparam logic [31:0] MaxCycles = 32'd10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] progLen;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [31:0] exitCode;
    logic [31:0] cycleCount;

    int          nVec  = 0;
    int          nFail = 0;
    logic [63:0] expQ[$];

    boot_run_ctrl_if bus ();

    boot_run_ctrl #(
        .LEN_W      (16),
        .LOAD_BASE  (LoadBase),
        .HALT_ADDR  (HaltAddr),
        .RST_CYCLES (RstCycles),
        .MAX_CYCLES (MaxCycles)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .prog_len    (progLen),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .exit_code   (exitCode),
        .cycle_count (cycleCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart(input logic [15:0] len);
        start   = 1'b1;
        progLen = len;
        tick();
        start   = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic driveStore(input logic [31:0] addr, input logic [31:0] data);
        bus.cpu_we        = 1'b1;
        bus.cpu_dataAddr  = addr;
        bus.cpu_writeData = data;
        tick();
        bus.cpu_we        = 1'b0;
    endtask

    // Bounded wait for cpu_n_reset to rise; returns ticks taken.
    task automatic waitRun(output int n);
        n = 0;
        while (bus.cpu_n_reset !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
    endtask

    // imem write monitor: every strobe must match the next expected word and last one cycle.
    initial begin
        logic        prevWe;
        logic [63:0] exp;
        prevWe = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.imem_we === 1'b1) begin
                nVec++;
                if (prevWe) begin
                    nFail++;
                    $display("FAIL imem_we_width: strobe high for 2+ cycles, required 1");
                end
                if (expQ.size() == 0) begin
                    nFail++;
                    $display("FAIL imem_unexpected: got addr=%h data=%h, required no write",
                             bus.imem_addr, bus.imem_wdata);
                end else begin
                    exp = expQ.pop_front();
                    if ({bus.imem_addr, bus.imem_wdata} !== exp) begin
                        nFail++;
                        $display("FAIL imem_write: got addr=%h data=%h, required addr=%h data=%h",
                                 bus.imem_addr, bus.imem_wdata, exp[63:32], exp[31:0]);
                    end
                end
            end
            prevWe = (bus.imem_we === 1'b1);
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        nVec++;
        if (bus.cpu_n_reset !== 1'b0 || bus.rx_ready !== 1'b0 || bus.imem_we !== 1'b0) begin
            nFail++;
            $display("FAIL reset_bus: got n_reset=%b rx_ready=%b imem_we=%b, required 0 0 0",
                     bus.cpu_n_reset, bus.rx_ready, bus.imem_we);
        end
        nVec++;
        if ({done, busy, timeout} !== 3'b000 || exitCode !== 32'd0 || cycleCount !== 32'd0) begin
            nFail++;
            $display("FAIL reset_status: got done=%b busy=%b timeout=%b exit=%h count=%0d, required 0",
                     done, busy, timeout, exitCode, cycleCount);
        end
        reset = 1'b0;
        tick();
        nVec++;
        if (busy !== 1'b0 || bus.rx_ready !== 1'b0) begin
            nFail++;
            $display("FAIL idle_hold: got busy=%b rx_ready=%b, required 0 0", busy, bus.rx_ready);
        end
    endtask

    task automatic test_load_run();
        logic [7:0] prog [8];
        int n;
        prog = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h33, 8'h80, 8'h10, 8'h00};
        expQ.push_back({LoadBase + 32'd0, 32'h0010_0013});
        expQ.push_back({LoadBase + 32'd4, 32'h0010_8033});
        pulseStart(16'd2);
        nVec++;
        if (bus.rx_ready !== 1'b1 || busy !== 1'b1) begin
            nFail++;
            $display("FAIL load_entry: got rx_ready=%b busy=%b, required 1 1", bus.rx_ready, busy);
        end
        for (int i = 0; i < 8; i++) begin
            sendByte(prog[i]);
            if (i == 2) begin
                // stall mid-word: load must simply wait
                tick();
                tick();
                tick();
                nVec++;
                if (bus.rx_ready !== 1'b1 || bus.cpu_n_reset !== 1'b0) begin
                    nFail++;
                    $display("FAIL load_stall: got rx_ready=%b n_reset=%b, required 1 0",
                             bus.rx_ready, bus.cpu_n_reset);
                end
            end
        end
        nVec++;
        if (bus.rx_ready !== 1'b0 || busy !== 1'b1 || bus.cpu_n_reset !== 1'b0) begin
            nFail++;
            $display("FAIL load_to_reset: got rx_ready=%b busy=%b n_reset=%b, required 0 1 0",
                     bus.rx_ready, busy, bus.cpu_n_reset);
        end
        waitRun(n);
        nVec++;
        if (n != int'(RstCycles)) begin
            nFail++;
            $display("FAIL reset_len: got %0d low cycles, required %0d", n, RstCycles);
        end
        nVec++;
        if (expQ.size() != 0) begin
            nFail++;
            $display("FAIL load_writes: got %0d writes missing, required 0", expQ.size());
        end
        nVec++;
        if (busy !== 1'b1 || cycleCount !== 32'd0) begin
            nFail++;
            $display("FAIL run_entry: got busy=%b count=%0d, required 1 0", busy, cycleCount);
        end
        driveStore(HaltAddr + 32'd4, 32'h55);
        nVec++;
        if (done !== 1'b0 || cycleCount !== 32'd1) begin
            nFail++;
            $display("FAIL non_halt_store: got done=%b count=%0d, required 0 1", done, cycleCount);
        end
        driveStore(HaltAddr, 32'h2A);
        nVec++;
        if (done !== 1'b1 || exitCode !== 32'h2A || timeout !== 1'b0 || bus.cpu_n_reset !== 1'b0
            || busy !== 1'b0 || cycleCount !== 32'd2) begin
            nFail++;
            $display("FAIL halt: got done=%b exit=%h timeout=%b n_reset=%b busy=%b count=%0d, required 1 2a 0 0 0 2",
                     done, exitCode, timeout, bus.cpu_n_reset, busy, cycleCount);
        end
    endtask

    task automatic test_timeout();
        int n;
        pulseStart(16'd0);
        nVec++;
        if (exitCode !== 32'd0 || done !== 1'b0 || busy !== 1'b1) begin
            nFail++;
            $display("FAIL restart_clear: got exit=%h done=%b busy=%b, required 0 0 1",
                     exitCode, done, busy);
        end
        waitRun(n);
        nVec++;
        if (n != int'(RstCycles)) begin
            nFail++;
            $display("FAIL zero_len_reset: got %0d low cycles, required %0d", n, RstCycles);
        end
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        nVec++;
        if (n != int'(MaxCycles) || timeout !== 1'b1 || cycleCount !== MaxCycles) begin
            nFail++;
            $display("FAIL timeout: got cycles=%0d timeout=%b count=%0d, required %0d 1 %0d",
                     n, timeout, cycleCount, MaxCycles, MaxCycles);
        end
        tick();
        nVec++;
        if (done !== 1'b1 || bus.cpu_n_reset !== 1'b0 || cycleCount !== MaxCycles) begin
            nFail++;
            $display("FAIL done_hold: got done=%b n_reset=%b count=%0d, required 1 0 %0d",
                     done, bus.cpu_n_reset, cycleCount, MaxCycles);
        end
    endtask

    task automatic test_halt_at_limit();
        int n;
        pulseStart(16'd0);
        nVec++;
        if (timeout !== 1'b0 || cycleCount !== 32'd0) begin
            nFail++;
            $display("FAIL restart_timeout_clear: got timeout=%b count=%0d, required 0 0",
                     timeout, cycleCount);
        end
        waitRun(n);
        for (int i = 0; i < int'(MaxCycles) - 1; i++) tick();
        driveStore(HaltAddr, 32'h77);
        nVec++;
        if (done !== 1'b1 || timeout !== 1'b0 || exitCode !== 32'h77 || cycleCount !== MaxCycles) begin
            nFail++;
            $display("FAIL halt_at_limit: got done=%b timeout=%b exit=%h count=%0d, required 1 0 77 %0d",
                     done, timeout, exitCode, cycleCount, MaxCycles);
        end
    endtask

    task automatic test_ignored_inputs();
        int n;
        pulseStart(16'd0);
        // halt store while still in reset must be ignored
        driveStore(HaltAddr, 32'h99);
        waitRun(n);
        nVec++;
        if (done !== 1'b0 || bus.cpu_n_reset !== 1'b1 || exitCode !== 32'd0) begin
            nFail++;
            $display("FAIL store_in_reset: got done=%b n_reset=%b exit=%h, required 0 1 0",
                     done, bus.cpu_n_reset, exitCode);
        end
        tick();
        tick();
        tick();
        pulseStart(16'd5);
        nVec++;
        if (cycleCount !== 32'd4 || bus.cpu_n_reset !== 1'b1 || bus.rx_ready !== 1'b0
            || done !== 1'b0) begin
            nFail++;
            $display("FAIL start_in_run: got count=%0d n_reset=%b rx_ready=%b done=%b, required 4 1 0 0",
                     cycleCount, bus.cpu_n_reset, bus.rx_ready, done);
        end
        driveStore(HaltAddr, 32'h5);
        nVec++;
        if (done !== 1'b1 || exitCode !== 32'h5 || cycleCount !== 32'd5) begin
            nFail++;
            $display("FAIL halt_after_start: got done=%b exit=%h count=%0d, required 1 5 5",
                     done, exitCode, cycleCount);
        end
    endtask

    task automatic test_abort_reload();
        int n;
        pulseStart(16'd3);
        sendByte(8'h11);
        sendByte(8'h22);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        nVec++;
        if (busy !== 1'b0 || done !== 1'b0 || bus.rx_ready !== 1'b0 || exitCode !== 32'd0
            || bus.cpu_n_reset !== 1'b0) begin
            nFail++;
            $display("FAIL abort_reset: got busy=%b done=%b rx_ready=%b exit=%h n_reset=%b, required 0 0 0 0 0",
                     busy, done, bus.rx_ready, exitCode, bus.cpu_n_reset);
        end
        expQ.push_back({LoadBase, 32'hDDCC_BBAA});
        pulseStart(16'd1);
        sendByte(8'hAA);
        sendByte(8'hBB);
        sendByte(8'hCC);
        sendByte(8'hDD);
        nVec++;
        if (bus.rx_ready !== 1'b0 || busy !== 1'b1) begin
            nFail++;
            $display("FAIL reload_done: got rx_ready=%b busy=%b, required 0 1", bus.rx_ready, busy);
        end
        waitRun(n);
        nVec++;
        if (n != int'(RstCycles) || expQ.size() != 0) begin
            nFail++;
            $display("FAIL reload_run: got reset_cycles=%0d pending=%0d, required %0d 0",
                     n, expQ.size(), RstCycles);
        end
        driveStore(HaltAddr, 32'h1);
        nVec++;
        if (done !== 1'b1 || exitCode !== 32'h1) begin
            nFail++;
            $display("FAIL reload_halt: got done=%b exit=%h, required 1 1", done, exitCode);
        end
    endtask

    initial begin
        reset             = 1'b1;
        start             = 1'b0;
        progLen           = 16'd0;
        bus.rx_valid      = 1'b0;
        bus.rx_data       = 8'd0;
        bus.cpu_we        = 1'b0;
        bus.cpu_dataAddr  = 32'd0;
        bus.cpu_writeData = 32'd0;
        test_reset();
        test_load_run();
        test_timeout();
        test_halt_at_limit();
        test_ignored_inputs();
        test_abort_reload();
        tick();
        tick();
        nVec++;
        if (expQ.size() != 0) begin
            nFail++;
            $display("FAIL scoreboard_drain: got %0d pending writes, required 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
